// File: rtl/chn_arb_pkg.sv
// Shared types and sizing helpers for the channel/endpoint arbiter family.
// No logic, no latency.
// No flow control; types only.
package chn_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } arb_state_e;

    localparam int NUM_CHN_DEF = 4;
    localparam int PTR_W       = $clog2(NUM_CHN_DEF);
    localparam int TIMER_W     = 8;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int chn_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chn_ep_arb_if.sv
// Channel-side bundle of the endpoint arbiter: requests, drive flags, token.
// No logic, no latency.
// Token is the only flow control: a channel drives TRN tx only while it holds it.
interface chn_ep_arb_if
    import chn_arb_pkg::*;
#(
    parameter int NUM_CHN = NUM_CHN_DEF
) ();

    localparam int PW = chn_idx_w(NUM_CHN);

    logic [NUM_CHN-1:0] chn_reqep;
    logic [NUM_CHN-1:0] chn_drvn;
    logic [NUM_CHN-1:0] chn_trn;
    logic [PW-1:0]      owner;
    logic               owner_vld;
    logic               arb_err;

    // Arbiter side.
    modport master (
        input  chn_reqep,
        input  chn_drvn,
        output chn_trn,
        output owner,
        output owner_vld,
        output arb_err
    );

    // Channel side.
    modport slave (
        output chn_reqep,
        output chn_drvn,
        input  chn_trn,
        input  owner,
        input  owner_vld,
        input  arb_err
    );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set req bit at or after ptr, wrapping.
// Purely combinational, zero latency.
// No flow control; hit is low when req is all zero.
module rr_pick
    import chn_arb_pkg::*;
#(
    parameter int N  = NUM_CHN_DEF,
    parameter int PW = PTR_W
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          hit,
    output logic [PW-1:0] idx
);

    logic [2*N-1:0] mask;
    logic [2*N-1:0] cand;

    // Duplicate req so the wrap-around becomes a plain lowest-bit search; the
    // lower copy is masked below ptr, the upper copy catches wrapped requesters.
    always_comb begin
        mask = {(2*N){1'b1}} << ptr;
        cand = {req, req} & mask;
        hit  = 1'b0;
        idx  = '0;
        for (int k = 2*N-1; k >= 0; k--) begin
            if (cand[k]) begin
                hit = 1'b1;
                idx = PW'(k % N);
            end
        end
    end

endmodule

// File: rtl/chn_ep_arb.sv
// Shares the endpoint TRN tx bus between channels with a round-robin one-hot token.
// Request to token 1 cycle from IDLE; drive-flag drop to token drop 1 cycle; >=1 idle cycle between owners.
// Token held until drive flag falls; an undriven grant is revoked after GRANT_TO+1 cycles.
module chn_ep_arb
    import chn_arb_pkg::*;
#(
    parameter int NUM_CHN  = NUM_CHN_DEF,
    parameter int GRANT_TO = 16
) (
    input  logic          clk250,
    input  logic          rst250_n,
    chn_ep_arb_if.master  bus
);

    localparam int PW = chn_idx_w(NUM_CHN);

    arb_state_e         state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      own_q, own_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [NUM_CHN-1:0] trn_q, trn_d;
    logic               vld_q, vld_d;
    logic               err_q, err_d;

    logic               pick_hit;
    logic [PW-1:0]      pick_idx;
    logic               do_grant;
    logic               do_release;
    logic               do_tick;

    rr_pick #(
        .N  (NUM_CHN),
        .PW (PW)
    ) u_pick (
        .req (bus.chn_reqep),
        .ptr (ptr_q),
        .hit (pick_hit),
        .idx (pick_idx)
    );

    // Registers: FSM state plus every output, so nothing reaches a port combinationally.
    always_ff @(posedge clk250 or negedge rst250_n) begin
        if (!rst250_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            timer_q <= '0;
            trn_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            timer_q <= timer_d;
            trn_q   <= trn_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    // Next state: grant from IDLE, wait for the drive flag in GRANT, never preempt in BUSY.
    // The timer starts at 0 on the grant edge, so timer==GRANT_TO means the token
    // has been up GRANT_TO+1 cycles with no drive.
    always_comb begin
        state_d    = state_q;
        do_grant   = 1'b0;
        do_release = 1'b0;
        do_tick    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_hit) begin
                    do_grant = 1'b1;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (bus.chn_drvn[own_q]) begin
                    state_d = BUSY;
                end else if (!bus.chn_reqep[own_q] ||
                             (timer_q == TIMER_W'(GRANT_TO))) begin
                    do_release = 1'b1;
                    state_d    = IDLE;
                end else begin
                    do_tick = 1'b1;
                end
            end
            BUSY: begin
                if (!bus.chn_drvn[own_q]) begin
                    do_release = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values; owner is deliberately kept across a release.
    // Any drive flag outside the current token bit is an error, whatever the state.
    always_comb begin
        ptr_d   = ptr_q;
        own_d   = own_q;
        timer_d = timer_q;
        trn_d   = trn_q;
        vld_d   = vld_q;
        if (do_grant) begin
            trn_d           = '0;
            trn_d[pick_idx] = 1'b1;
            own_d           = pick_idx;
            vld_d           = 1'b1;
            timer_d         = '0;
        end
        if (do_release) begin
            trn_d = '0;
            vld_d = 1'b0;
            ptr_d = (own_q == PW'(NUM_CHN-1)) ? '0 : own_q + 1'b1;
        end
        if (do_tick) begin
            timer_d = timer_q + 1'b1;
        end
        err_d = |(bus.chn_drvn & ~trn_q);
    end

    assign bus.chn_trn   = trn_q;
    assign bus.owner     = own_q;
    assign bus.owner_vld = vld_q;
    assign bus.arb_err   = err_q;

endmodule

// File: tb/tb_chn_ep_arb.sv
// Bench for chn_ep_arb: directed scenarios plus randomized channel agents, all
// outputs checked every cycle against a queue filled by a behavioural model.
module tb_chn_ep_arb;
    import chn_arb_pkg::*;

    localparam int N   = 4;
    localparam int GTO = 16;

    logic clk250   = 1'b0;
    logic rst250_n = 1'b0;
    always #2 clk250 = ~clk250;

    logic [N-1:0] req_r = '0;
    logic [N-1:0] drv_r = '0;
    logic [N-1:0] rogue = '0;

    chn_ep_arb_if #(.NUM_CHN(N)) bus ();
    assign bus.chn_reqep = req_r;
    assign bus.chn_drvn  = drv_r | rogue;

    chn_ep_arb #(.NUM_CHN(N), .GRANT_TO(GTO)) dut (
        .clk250   (clk250),
        .rst250_n (rst250_n),
        .bus      (bus.master)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [N-1:0] trn;
        logic [1:0]   own;
        logic         vld;
        logic         err;
    } obs_t;

    obs_t exp_q[$];

    // Reference model: who holds the token, for how many cycles it has been up,
    // whether the holder has started driving, and where the rotation resumes.
    int m_hold  = -1;
    int m_last  = 0;
    int m_ptr   = 0;
    int m_age   = 0;
    bit m_drive = 1'b0;

    task automatic model_release();
        m_ptr  = (m_hold + 1) % N;
        m_hold = -1;
    endtask

    task automatic model_step();
        obs_t o;
        int   j;
        bit   found;
        if (!rst250_n) begin
            m_hold = -1; m_last = 0; m_ptr = 0; m_age = 0; m_drive = 1'b0;
            exp_q.delete();
            return;
        end
        o.err = 1'b0;
        for (int k = 0; k < N; k++)
            if (bus.chn_drvn[k] && (k != m_hold)) o.err = 1'b1;
        if (m_hold < 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (!found && bus.chn_reqep[j]) begin
                    found = 1'b1; m_hold = j; m_last = j; m_age = 1; m_drive = 1'b0;
                end
            end
        end else if (m_drive) begin
            if (!bus.chn_drvn[m_hold]) model_release();
        end else if (bus.chn_drvn[m_hold]) begin
            m_drive = 1'b1;
        end else if (!bus.chn_reqep[m_hold] || m_age == GTO + 1) begin
            model_release();
        end else begin
            m_age++;
        end
        o.trn = (m_hold >= 0) ? 4'(1 << m_hold) : 4'b0;
        o.vld = (m_hold >= 0);
        o.own = 2'(m_last);
        exp_q.push_back(o);
    endtask

    initial forever begin
        @(posedge clk250 or negedge rst250_n);
        model_step();
    end

    // Monitor: one expected entry per clock; during reset everything must read zero.
    initial forever begin
        obs_t e;
        @(negedge clk250);
        if (!rst250_n) begin
            chk("rst_trn", int'(bus.chn_trn), 0);
            chk("rst_vld", int'(bus.owner_vld), 0);
            chk("rst_owner", int'(bus.owner), 0);
            chk("rst_err", int'(bus.arb_err), 0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_trn", int'(bus.chn_trn), int'(e.trn));
            chk("sb_owner", int'(bus.owner), int'(e.own));
            chk("sb_vld", int'(bus.owner_vld), int'(e.vld));
            chk("sb_err", int'(bus.arb_err), int'(e.err));
        end
    end

    task automatic step();
        @(posedge clk250);
        #1;
    endtask

    int gl[$];
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    int beh[N];
    int len[N];
    bit had[N];

    initial begin
        int ng, dleft, to, hi, j;
        bit zero_seen;

        repeat (3) step();
        rst250_n = 1'b1;
        repeat (2) step();

        // Single request, long burst, then rotation resumes after the owner.
        req_r = 4'b0100;
        step();
        chk("t1_trn", int'(bus.chn_trn), 4'b0100);
        chk("t1_owner", int'(bus.owner), 2);
        step();
        drv_r[2] = 1'b1;
        repeat (13) step();
        drv_r = '0; req_r = '0;
        step();
        chk("t1_release", int'(bus.chn_trn), 0);
        req_r = 4'b1001;
        step();
        chk("t1_ptr3", int'(bus.owner), 3);
        drv_r[3] = 1'b1;
        step(); step();
        drv_r = '0; req_r = '0;
        step(); step();

        // Everyone requests; each owner drives 3 cycles.
        req_r = 4'b1111; ng = 0; dleft = 0; to = 0; zero_seen = 1'b1;
        while ((ng < 5 || dleft > 0) && to < 200) begin
            step();
            to++;
            if (bus.chn_trn == '0) zero_seen = 1'b1;
            if (dleft > 0) begin
                dleft--;
                if (dleft == 0) begin
                    drv_r = '0;
                    if (ng == 5) req_r = '0;
                end
            end else if (bus.owner_vld && drv_r == '0) begin
                chk("t2_gap", int'(zero_seen), 1);
                zero_seen = 1'b0;
                gl.push_back(int'(bus.owner));
                ng++;
                drv_r[bus.owner] = 1'b1;
                dleft = 3;
            end
        end
        chk("t2_timeout", int'(to < 200), 1);
        chk("t2_count", gl.size(), 5);
        for (int i = 0; i < 5 && i < gl.size(); i++) chk("t2_order", gl[i], exp_ord[i]);
        step(); step();

        // Undriven grant is revoked; a waiting channel gets the next token.
        req_r = 4'b0010;
        step();
        chk("t3_grant1", int'(bus.chn_trn), 4'b0010);
        hi = 1; to = 0;
        while (to < 40) begin
            if (hi == 3) req_r[3] = 1'b1;
            step();
            to++;
            if (bus.chn_trn == 4'b0010) hi++;
            else break;
        end
        chk("t3_hi_cycles", hi, GTO + 1);
        chk("t3_gap", int'(bus.chn_trn), 0);
        step();
        chk("t3_ch3", int'(bus.chn_trn), 4'b1000);
        req_r = '0;
        step();
        chk("t3_withdraw", int'(bus.chn_trn), 0);
        step();

        // Rogue drive flag while channel 0 is busy.
        req_r = 4'b0001;
        step();
        chk("t4_owner", int'(bus.owner), 0);
        drv_r[0] = 1'b1;
        step(); step();
        rogue[2] = 1'b1;
        step();
        rogue = '0;
        chk("t4_err", int'(bus.arb_err), 1);
        chk("t4_trn", int'(bus.chn_trn), 4'b0001);
        step();
        chk("t4_err_clr", int'(bus.arb_err), 0);
        chk("t4_trn_hold", int'(bus.chn_trn), 4'b0001);
        drv_r = '0; req_r = '0;
        step(); step();

        // Withdrawn request in GRANT, then reset in the middle of a burst.
        req_r = 4'b0010;
        step();
        chk("t5_owner1", int'(bus.owner), 1);
        req_r = '0;
        step();
        chk("t5_withdraw", int'(bus.chn_trn), 0);
        step();
        req_r = 4'b0100;
        step();
        chk("t5_owner2", int'(bus.owner), 2);
        drv_r[2] = 1'b1;
        step(); step();
        rst250_n = 1'b0;
        #1;
        chk("t5_async_trn", int'(bus.chn_trn), 0);
        chk("t5_async_vld", int'(bus.owner_vld), 0);
        chk("t5_async_owner", int'(bus.owner), 0);
        drv_r = '0; req_r = 4'b1101;
        step();
        rst250_n = 1'b1;
        step();
        chk("t5_post_rst_owner", int'(bus.owner), 0);
        chk("t5_post_rst_trn", int'(bus.chn_trn), 4'b0001);
        req_r = '0;
        step(); step();

        // Randomized reactive channels with occasional rogue drive pulses.
        for (int k = 0; k < N; k++) begin beh[k] = 0; len[k] = 0; had[k] = 1'b0; end
        repeat (3000) begin
            step();
            rogue = '0;
            for (int k = 0; k < N; k++) begin
                if (!req_r[k]) begin
                    if ($urandom_range(0, 5) == 0) begin
                        req_r[k] = 1'b1;
                        beh[k]   = int'($urandom_range(0, 2));
                        len[k]   = int'($urandom_range(1, 5));
                        had[k]   = 1'b0;
                    end
                end else if (bus.chn_trn[k]) begin
                    had[k] = 1'b1;
                    if (beh[k] == 0) begin
                        if (!drv_r[k]) drv_r[k] = 1'b1;
                        else if (len[k] == 1) begin drv_r[k] = 1'b0; req_r[k] = 1'b0; end
                        else len[k]--;
                    end else if (beh[k] == 2) begin
                        if (len[k] == 1) req_r[k] = 1'b0;
                        else len[k]--;
                    end
                end else if (had[k]) begin
                    req_r[k] = 1'b0;
                    drv_r[k] = 1'b0;
                end
            end
            if ($urandom_range(0, 29) == 0) begin
                j = int'($urandom_range(0, N - 1));
                if (!bus.chn_trn[j] && !drv_r[j]) rogue[j] = 1'b1;
            end
        end
        rogue = '0; drv_r = '0; req_r = '0;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
